// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared types and helpers for the cacheline burst adapter: default geometry,
// FSM state encoding and line-address alignment.
package cacheline_burst_adapter_pkg;

    localparam int DEF_LINE_W  = 256;
    localparam int DEF_BURST_W = 64;
    localparam int DEF_ADDR_W  = 32;

    // Widest address the alignment helper handles; callers cast in and out.
    localparam int ADDR_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        DONE
    } state_e;

    function automatic logic [ADDR_MAX_W-1:0] align_line(
        input logic [ADDR_MAX_W-1:0] addr,
        input int unsigned           ofs
    );
        logic [ADDR_MAX_W-1:0] mask;
        mask = '1;
        mask = mask << ofs;
        return addr & mask;
    endfunction

endpackage

// File: rtl/cacheline_burst_adapter.sv
// Bridges a cache dfp port to banked memory: gathers read beats into a line
// and serialises a written line into beats, one transaction at a time.
module cacheline_burst_adapter
    import cacheline_burst_adapter_pkg::*;
#(
    parameter int LINE_W  = DEF_LINE_W,
    parameter int BURST_W = DEF_BURST_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  dfp_addr,
    input  logic               dfp_read,
    input  logic               dfp_write,
    input  logic [LINE_W-1:0]  dfp_wdata,
    output logic [LINE_W-1:0]  dfp_rdata,
    output logic               dfp_resp,
    output logic [ADDR_W-1:0]  bmem_addr,
    output logic               bmem_read,
    output logic               bmem_write,
    output logic [BURST_W-1:0] bmem_wdata,
    input  logic               bmem_ready,
    input  logic [ADDR_W-1:0]  bmem_raddr,
    input  logic [BURST_W-1:0] bmem_rdata,
    input  logic               bmem_rvalid
);

    localparam int          BEATS = LINE_W / BURST_W;
    localparam int unsigned OFS   = $clog2(LINE_W / 8);
    localparam int          CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  line_q, line_d;     // write source or read assembly
    logic [LINE_W-1:0]  rline_q, rline_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic               resp_q, resp_d;
    logic [BURST_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0]  addr_aligned;

    assign addr_aligned = ADDR_W'(align_line(ADDR_MAX_W'(dfp_addr), OFS));

    // NOTE: every *_d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        rline_d = rline_q;

        case (state_q)
            IDLE: begin
                if (dfp_write) begin
                    addr_d  = addr_aligned;
                    line_d  = dfp_wdata;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (dfp_read) begin
                    addr_d  = addr_aligned;
                    cnt_d   = '0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (bmem_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Beats tagged for another line belong to someone else.
                if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                    line_d[int'(cnt_q) * BURST_W +: BURST_W] = bmem_rdata;
                    if (cnt_q == LAST_BEAT) begin
                        rline_d = line_d;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                    else                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state so nothing on dfp_* reaches bmem_* combinationally.
        read_d  = (state_d == RD_REQ);
        write_d = (state_d == WR_BURST);
        resp_d  = (state_d == DONE);
        wdata_d = (state_d == WR_BURST) ? line_d[int'(cnt_d) * BURST_W +: BURST_W] : '0;
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    // NOTE: the line buffers are reset too, since dfp_rdata must read zero
    // after reset rather than stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rline_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rline_q <= rline_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
            wdata_q <= wdata_d;
        end
    end

    assign dfp_rdata  = rline_q;
    assign dfp_resp   = resp_q;
    assign bmem_addr  = addr_q;
    assign bmem_read  = read_q;
    assign bmem_write = write_q;
    assign bmem_wdata = wdata_q;

endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
- Parametrised successor to the read-only cacheline adapter.
- Sits between the cache dfp port and the banked memory interface.
- Read path: gathers BEATS bursts of BURST_W bits into one LINE_W line, filtering on the returned raddr.
- Write path (new): serialises a LINE_W line into BEATS bursts under bmem_ready flow control.
- One outstanding transaction at a time.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, banked-memory data beat width; LINE_W must be a multiple of BURST_W.
- ADDR_W, 32, byte address width.
- Derived locally: BEATS = LINE_W/BURST_W; OFS = log2(LINE_W/8).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- dfp_addr  in  ADDR_W  cache request byte address.
- dfp_read  in  1  line read request; held by upstream until dfp_resp.
- dfp_write  in  1  line write request; held by upstream until dfp_resp.
- dfp_wdata  in  LINE_W  line to write.
- dfp_rdata  out  LINE_W  assembled line; valid when dfp_resp=1, held afterwards.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  ADDR_W  line-aligned address (low OFS bits zero).
- bmem_read  out  1  read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BURST_W  write beat data.
- bmem_ready  in  1  memory accepts command/beat this cycle.
- bmem_raddr  in  ADDR_W  address tag of the returning beat.
- bmem_rdata  in  BURST_W  returning read beat.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset (async, any state):
  - state=IDLE, beat counter=0.
  - All outputs 0, including dfp_rdata and the latched address.
  - rvalid beats arriving after reset with no read outstanding are ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE.
- IDLE:
  - Requests are sampled only in this state. dfp_write has priority over dfp_read if both are high.
  - On dfp_write: latch addr (aligned) and dfp_wdata, set cnt=0, go to WR_BURST.
  - On dfp_read: latch addr (aligned), set cnt=0, go to RD_REQ.
  - Otherwise stay.
- RD_REQ:
  - Drive bmem_read=1 and bmem_addr.
  - If bmem_ready: go to RD_WAIT next cycle. Otherwise hold.
  - Exactly one accepted read command per line.
- RD_WAIT:
  - On bmem_rvalid with bmem_raddr == latched addr: store bmem_rdata into line bits [cnt*BURST_W +: BURST_W], cnt++.
  - A beat with mismatched raddr is dropped and does not advance cnt.
  - After the beat where cnt==BEATS-1: go to DONE.
  - Beats may arrive with gaps.
  - Latency: dfp_resp is asserted the cycle after the last beat.
- WR_BURST:
  - bmem_write=1, bmem_addr=latched addr, bmem_wdata = beat cnt of latched line.
  - cnt advances only on cycles with bmem_ready=1. If ready=0, all outputs hold.
  - When the beat with cnt==BEATS-1 is accepted: go to DONE.
  - bmem_write stays high continuously across all beats.
- DONE:
  - dfp_resp=1 for exactly this cycle, then IDLE.
  - No request is sampled in the DONE cycle.
  - dfp_rdata holds its read line until the next read completes; it is unchanged by writes.
- Outputs are registered or decoded from state only. No combinational path from dfp_* to bmem_*.
- Counter width is log2(BEATS), minimum 1. No wrap is possible because the counter exits at BEATS-1.

Decomposition:
- Shared package (e.g. cache_pkg):
  - Parameters LINE_W and BURST_W.
  - Typedef for the state enum.
  - Function align_line(addr) returning the address with the low OFS bits cleared.
- No sub-module is needed; a single FSM plus datapath is sufficient.
- The beat mux/demux may be factored as burst_slicer if it is reused by the future writeback buffer.

Test Plan:
- Read, contiguous beats: dfp_read, dfp_addr=0x1eceb004, ready=1 → bmem_read for 1 cycle with bmem_addr=0x1eceb000. Beats 0x1111111111111111, 0x2222..., 0x3333..., 0x4444... on consecutive cycles → dfp_resp 1 cycle after beat 4, dfp_rdata=0x4444...3333...2222...1111....
- Read, gaps and stray beat: same request, rvalid gaps of 3 cycles, plus a stray beat with raddr=0x1eceb020 → stray beat ignored, same line assembled, dfp_resp exactly once.
- Write, backpressure: dfp_write, addr=0x00001040, wdata=0xDDDD..CCCC..BBBB..AAAA.., ready toggling 1,0,1,0,... → bmem_wdata sequence AAAA, BBBB, CCCC, DDDD, each held while ready=0. bmem_addr=0x00001040 throughout. dfp_resp the cycle after the 4th accept.
- Simultaneous read and write, ready stuck low: dfp_read and dfp_write both high, ready=0 for 5 cycles → write is serviced first, bmem_read never asserts, bmem_write stays high. After resp, the read is then served.
- Async reset mid-read: rst asserted (mid-cycle) after 2 of 4 beats → all outputs 0 immediately, state=IDLE. Remaining rvalid beats produce no dfp_resp. A fresh read then completes normally.
- Parameter sweep: LINE_W=512, BURST_W=64 (BEATS=8) and LINE_W=256, BURST_W=128 (BEATS=2) → correct beat ordering, and resp after exactly BEATS accepted beats.
